npc_unit: RTL and testbench

- Fetch-side consumer of the ID-stage branch comparator result. Owns the fetch PC register and the ID-stage PC copy.
- Applies branch, jump, jr, exception-entry and eret redirects with MIPS delayed-branch semantics.
- Sits between the hazard/exception controllers and the instruction memory address port.

---
 rtl/mips_pkg.sv | 16 +
 rtl/npc_target.sv | 22 ++
 rtl/npc_unit.sv | 129 ++++++++++++
 tb/tb_npc_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side constants and the npc_unit stall-tracking state encoding.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [XLEN-1:0] DEF_IM_LO      = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_HI      = 32'h0000_6ffc;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_target.sv
// Candidate next-PC addresses: taken branch, j/jal target and sequential fetch.
module npc_target
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc_f_i,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [15:0]     imm16_i,
  input  logic [25:0]     imm26_i,
  output logic [XLEN-1:0] br_tgt_o,
  output logic [XLEN-1:0] j_tgt_o,
  output logic [XLEN-1:0] seq_pc_o
);

  logic [XLEN-1:0] br_off;

  // Word offset, sign-extended, relative to the delay-slot address.
  assign br_off   = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign br_tgt_o = pc_d_i + XLEN'(4) + br_off;
  assign j_tgt_o  = {pc_d_i[31:28], imm26_i, 2'b00};
  assign seq_pc_o = pc_f_i + XLEN'(4);

endmodule

// File: rtl/npc_unit.sv
// Fetch PC / ID-stage PC owner with delayed-branch redirect handling.
// Optional redirect/stall counters are built when NPC_REDIRECT_CNT_EN is defined.
module npc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] IM_LO      = DEF_IM_LO,
  parameter logic [31:0] IM_HI      = DEF_IM_HI
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_req,
  input  logic        cmp_result,
  input  logic [15:0] imm16,
  input  logic        j_req,
  input  logic [25:0] imm26,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic        bd_d,
  output logic        flush_fd,
  output logic        adel_f
`ifdef NPC_REDIRECT_CNT_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] stall_cyc
`endif
);

  npc_state_e      state_q;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic            bd_d_q, bd_d_d;
  logic [XLEN-1:0] br_tgt, j_tgt, seq_pc;
  logic            is_ctrl;

  npc_target u_target (
    .pc_f_i   (pc_f_q),
    .pc_d_i   (pc_d_q),
    .imm16_i  (imm16),
    .imm26_i  (imm26),
    .br_tgt_o (br_tgt),
    .j_tgt_o  (j_tgt),
    .seq_pc_o (seq_pc)
  );

  assign is_ctrl = br_req | j_req | jr_req;

  // Next-PC priority: exception, eret, stall, then D-stage control transfers.
  always_comb begin
    pc_f_d = seq_pc;
    pc_d_d = pc_d_q;
    bd_d_d = bd_d_q;
    if (exc_req) begin
      pc_f_d = EXC_VECTOR;
      pc_d_d = EXC_VECTOR;
      bd_d_d = 1'b0;
    end else begin
      if (eret_req)                 pc_f_d = epc;
      else if (stall)               pc_f_d = pc_f_q;
      else if (br_req & cmp_result) pc_f_d = br_tgt;
      else if (j_req)               pc_f_d = j_tgt;
      else if (jr_req)              pc_f_d = jr_addr;
      if (!stall) begin
        pc_d_d = pc_f_q;
        bd_d_d = is_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_f_q  <= RESET_PC;
      pc_d_q  <= RESET_PC;
      bd_d_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (stall && !exc_req) state_q <= HOLD;
        HOLD:    if (!stall || exc_req) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      pc_f_q <= pc_f_d;
      pc_d_q <= pc_d_d;
      bd_d_q <= bd_d_d;
    end
  end

  assign pc_f     = pc_f_q;
  assign pc_d     = pc_d_q;
  assign bd_d     = bd_d_q;
  assign flush_fd = eret_req & ~exc_req;
  assign adel_f   = (pc_f_q[1:0] != 2'b00) | (pc_f_q < IM_LO) | (pc_f_q > IM_HI);

`ifdef NPC_REDIRECT_CNT_EN
  logic [31:0] taken_cnt_q, stall_cyc_q;
  logic        redirect_applied;

  assign redirect_applied = ~exc_req & ~eret_req & ~stall &
                            ((br_req & cmp_result) | j_req | jr_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (redirect_applied) taken_cnt_q <= taken_cnt_q + 32'd1;
      if (state_q == HOLD)  stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign stall_cyc = stall_cyc_q;
`endif

  // HOLD is only reachable through a stalled cycle.
  a_hold_after_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD) |-> $past(stall));

  a_ctrl_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({br_req, j_req, jr_req, eret_req}));

endmodule

// File: tb/tb_npc_unit.sv
// Directed testbench for npc_unit: sequencing, delayed branches, stall, exception/eret.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_req, cmp_result, j_req, jr_req, exc_req, eret_req;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_addr, epc;
  logic [31:0] pc_f, pc_d;
  logic        bd_d, flush_fd, adel_f;
`ifdef NPC_REDIRECT_CNT_EN
  logic [31:0] taken_cnt, stall_cyc;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  npc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_req     (br_req),
    .cmp_result (cmp_result),
    .imm16      (imm16),
    .j_req      (j_req),
    .imm26      (imm26),
    .jr_req     (jr_req),
    .jr_addr    (jr_addr),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc_f       (pc_f),
    .pc_d       (pc_d),
    .bd_d       (bd_d),
    .flush_fd   (flush_fd),
    .adel_f     (adel_f)
`ifdef NPC_REDIRECT_CNT_EN
    ,
    .taken_cnt  (taken_cnt),
    .stall_cyc  (stall_cyc)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_req = 0; cmp_result = 0; j_req = 0; jr_req = 0;
    exc_req = 0; eret_req = 0; imm16 = '0; imm26 = '0; jr_addr = '0; epc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #12;
    vectors++; if (pc_f !== 32'h3000) begin miscompares++; $display("FAIL reset_pc_f got %h exp %h", pc_f, 32'h3000); end
    vectors++; if (pc_d !== 32'h3000) begin miscompares++; $display("FAIL reset_pc_d got %h exp %h", pc_d, 32'h3000); end
    vectors++; if (bd_d !== 1'b0) begin miscompares++; $display("FAIL reset_bd_d got %b exp 0", bd_d); end
    vectors++; if (flush_fd !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b exp 0", flush_fd); end
    vectors++; if (adel_f !== 1'b0) begin miscompares++; $display("FAIL reset_adel got %b exp 0", adel_f); end
    rst_n = 1'b1;
    tick();
    vectors++; if (pc_f !== 32'h3004 || pc_d !== 32'h3000 || bd_d !== 1'b0) begin miscompares++; $display("FAIL seq1 got pc_f=%h pc_d=%h bd=%b exp 3004/3000/0", pc_f, pc_d, bd_d); end
    tick();
    vectors++; if (pc_f !== 32'h3008 || pc_d !== 32'h3004 || bd_d !== 1'b0) begin miscompares++; $display("FAIL seq2 got pc_f=%h pc_d=%h bd=%b exp 3008/3004/0", pc_f, pc_d, bd_d); end
    tick();
    vectors++; if (pc_f !== 32'h300c || pc_d !== 32'h3008) begin miscompares++; $display("FAIL seq3 got pc_f=%h pc_d=%h exp 300c/3008", pc_f, pc_d); end
  endtask

  task automatic test_branch_taken();
    br_req = 1; cmp_result = 1; imm16 = 16'hfffe;
    tick();
    vectors++; if (pc_f !== 32'h3004 || pc_d !== 32'h300c || bd_d !== 1'b1) begin miscompares++; $display("FAIL br_taken got pc_f=%h pc_d=%h bd=%b exp 3004/300c/1", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h3008 || pc_d !== 32'h3004 || bd_d !== 1'b0) begin miscompares++; $display("FAIL br_target_in_d got pc_f=%h pc_d=%h bd=%b exp 3008/3004/0", pc_f, pc_d, bd_d); end
  endtask

  task automatic test_branch_not_taken();
    br_req = 1; cmp_result = 0; imm16 = 16'h0040;
    tick();
    vectors++; if (pc_f !== 32'h300c || pc_d !== 32'h3008 || bd_d !== 1'b1) begin miscompares++; $display("FAIL br_nt got pc_f=%h pc_d=%h bd=%b exp 300c/3008/1", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h3010 || pc_d !== 32'h300c || bd_d !== 1'b0) begin miscompares++; $display("FAIL br_nt_after got pc_f=%h pc_d=%h bd=%b exp 3010/300c/0", pc_f, pc_d, bd_d); end
    tick();
  endtask

  task automatic test_jump();
    j_req = 1; imm26 = 26'h0000c40;
    tick();
    vectors++; if (pc_f !== 32'h3100 || pc_d !== 32'h3014 || bd_d !== 1'b1) begin miscompares++; $display("FAIL j got pc_f=%h pc_d=%h bd=%b exp 3100/3014/1", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h3104 || pc_d !== 32'h3100) begin miscompares++; $display("FAIL j_after got pc_f=%h pc_d=%h exp 3104/3100", pc_f, pc_d); end
    jr_req = 1; jr_addr = 32'h3002;
    tick();
    vectors++; if (pc_f !== 32'h3002 || pc_d !== 32'h3104 || bd_d !== 1'b1) begin miscompares++; $display("FAIL jr got pc_f=%h pc_d=%h bd=%b exp 3002/3104/1", pc_f, pc_d, bd_d); end
    vectors++; if (adel_f !== 1'b1) begin miscompares++; $display("FAIL jr_misaligned_adel got %b exp 1", adel_f); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h3006 || adel_f !== 1'b1) begin miscompares++; $display("FAIL jr_seq got pc_f=%h adel=%b exp 3006/1", pc_f, adel_f); end
  endtask

  task automatic test_bounds();
    jr_req = 1; jr_addr = 32'h6ffc;
    tick();
    vectors++; if (pc_f !== 32'h6ffc || adel_f !== 1'b0) begin miscompares++; $display("FAIL im_hi got pc_f=%h adel=%b exp 6ffc/0", pc_f, adel_f); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h7000 || adel_f !== 1'b1) begin miscompares++; $display("FAIL above_hi got pc_f=%h adel=%b exp 7000/1", pc_f, adel_f); end
    jr_req = 1; jr_addr = 32'h2ffc;
    tick();
    vectors++; if (pc_f !== 32'h2ffc || adel_f !== 1'b1) begin miscompares++; $display("FAIL below_lo got pc_f=%h adel=%b exp 2ffc/1", pc_f, adel_f); end
    jr_addr = 32'hffff_fffc;
    tick();
    vectors++; if (pc_f !== 32'hffff_fffc || adel_f !== 1'b1) begin miscompares++; $display("FAIL top_addr got pc_f=%h adel=%b exp fffffffc/1", pc_f, adel_f); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h0 || adel_f !== 1'b1) begin miscompares++; $display("FAIL wrap got pc_f=%h adel=%b exp 0/1", pc_f, adel_f); end
    jr_req = 1; jr_addr = 32'h3000;
    tick();
    vectors++; if (pc_f !== 32'h3000 || adel_f !== 1'b0 || pc_d !== 32'h0) begin miscompares++; $display("FAIL im_lo got pc_f=%h pc_d=%h adel=%b exp 3000/0/0", pc_f, pc_d, adel_f); end
    clear_inputs();
    tick();
    tick();
    vectors++; if (pc_f !== 32'h3008 || pc_d !== 32'h3004 || bd_d !== 1'b0) begin miscompares++; $display("FAIL bounds_resync got pc_f=%h pc_d=%h bd=%b exp 3008/3004/0", pc_f, pc_d, bd_d); end
  endtask

  task automatic test_stall();
    stall = 1; br_req = 1; cmp_result = 1; imm16 = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (pc_f !== 32'h3008 || pc_d !== 32'h3004 || bd_d !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d got pc_f=%h pc_d=%h bd=%b exp 3008/3004/0", i, pc_f, pc_d, bd_d); end
    end
    stall = 0;
    tick();
    vectors++; if (pc_f !== 32'h3018 || pc_d !== 32'h3008 || bd_d !== 1'b1) begin miscompares++; $display("FAIL stall_release got pc_f=%h pc_d=%h bd=%b exp 3018/3008/1", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h301c || pc_d !== 32'h3018 || bd_d !== 1'b0) begin miscompares++; $display("FAIL stall_after got pc_f=%h pc_d=%h bd=%b exp 301c/3018/0", pc_f, pc_d, bd_d); end
  endtask

  task automatic test_exception();
    exc_req = 1; stall = 1; eret_req = 1; epc = 32'h3020;
    #1;
    vectors++; if (flush_fd !== 1'b0) begin miscompares++; $display("FAIL exc_masks_flush got %b exp 0", flush_fd); end
    tick();
    vectors++; if (pc_f !== 32'h4180 || pc_d !== 32'h4180 || bd_d !== 1'b0) begin miscompares++; $display("FAIL exc_entry got pc_f=%h pc_d=%h bd=%b exp 4180/4180/0", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h4184 || pc_d !== 32'h4180) begin miscompares++; $display("FAIL exc_seq got pc_f=%h pc_d=%h exp 4184/4180", pc_f, pc_d); end
    eret_req = 1; epc = 32'h3020;
    #1;
    vectors++; if (flush_fd !== 1'b1) begin miscompares++; $display("FAIL eret_flush got %b exp 1", flush_fd); end
    tick();
    vectors++; if (pc_f !== 32'h3020 || pc_d !== 32'h4184 || bd_d !== 1'b0) begin miscompares++; $display("FAIL eret got pc_f=%h pc_d=%h bd=%b exp 3020/4184/0", pc_f, pc_d, bd_d); end
    clear_inputs();
    #1;
    vectors++; if (flush_fd !== 1'b0) begin miscompares++; $display("FAIL eret_flush_clear got %b exp 0", flush_fd); end
    tick();
    vectors++; if (pc_f !== 32'h3024 || pc_d !== 32'h3020) begin miscompares++; $display("FAIL eret_seq got pc_f=%h pc_d=%h exp 3024/3020", pc_f, pc_d); end
  endtask

  task automatic test_back_to_back();
    j_req = 1; imm26 = 26'h0000d00;
    tick();
    vectors++; if (pc_f !== 32'h3400 || pc_d !== 32'h3024 || bd_d !== 1'b1) begin miscompares++; $display("FAIL b2b_j1 got pc_f=%h pc_d=%h bd=%b exp 3400/3024/1", pc_f, pc_d, bd_d); end
    imm26 = 26'h0000e00;
    tick();
    vectors++; if (pc_f !== 32'h3800 || pc_d !== 32'h3400 || bd_d !== 1'b1) begin miscompares++; $display("FAIL b2b_j2 got pc_f=%h pc_d=%h bd=%b exp 3800/3400/1", pc_f, pc_d, bd_d); end
    clear_inputs();
    tick();
    vectors++; if (pc_f !== 32'h3804 || pc_d !== 32'h3800 || bd_d !== 1'b0) begin miscompares++; $display("FAIL b2b_after got pc_f=%h pc_d=%h bd=%b exp 3804/3800/0", pc_f, pc_d, bd_d); end
  endtask

  initial begin
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_jump();
    test_bounds();
    test_stall();
    test_exception();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
